input_debounce_scan: RTL

Front-end stage of the BCD display path. It sits directly upstream of the BCD splitter/digit multiplexer and:
- synchronizes and debounces the five value switches and the selector switch;
- generates the slow scan clock `clk2` that steps the splitter's digit sequence;
- presents `input_val` and `selector` so they change only while `clk2` is low, so the splitter never sees a value change mid-sequence at a `clk2` rising edge.

---
 rtl/input_debounce_scan.sv | 83 ++++++++
 1 files changed

// File: rtl/input_debounce_scan.sv
// Switch front end: 2-flop sync + per-bit debounce, slow scan clock clk2, outputs loaded only on clk2 falls.
// Latency DEB_CYCLES+1 to debounced bit, then 1..2*SCAN_DIV to outputs; no backpressure.
module input_debounce_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sw_raw,
  input  logic       sel_raw,
  output logic       clk2,
  output logic [4:0] input_val,
  output logic       selector,
  output logic       change_strobe
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  logic [5:0]    sync1_q, sync2_q;
  logic [5:0]    deb_q, deb_d;
  logic [DW-1:0] cnt_q [6];
  logic [DW-1:0] cnt_d [6];
  logic [SW-1:0] scan_q, scan_d;
  logic          clk2_q, clk2_d;
  logic [5:0]    out_q, out_d;
  logic          strobe_q, strobe_d;
  logic          wrap, load;

  // Any agreeing cycle clears the count, so only an unbroken run of DEB_CYCLES accepts a level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    wrap     = (scan_q == SCAN_MAX);
    scan_d   = wrap ? '0 : scan_q + 1'b1;
    clk2_d   = clk2_q ^ wrap;
    load     = wrap & clk2_q;
    out_d    = load ? deb_q : out_q;
    strobe_d = load && (deb_q != out_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      scan_q   <= '0;
      clk2_q   <= 1'b0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= {sel_raw, sw_raw};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      scan_q   <= scan_d;
      clk2_q   <= clk2_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  assign clk2          = clk2_q;
  assign input_val     = out_q[4:0];
  assign selector      = out_q[5];
  assign change_strobe = strobe_q;

endmodule
